// File: rtl/ssram_master.sv
// Bus initiator for the one-hot row/column register bus: turns one valid/ready
// request into a two-cycle strobe window followed by a select-free recovery cycle.
`timescale 1ns/1ps
module ssram_master #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [7:0]       req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [15:0]      row,
  output logic [15:0]      column,
  output logic             we,
  output logic             re,
  inout  wire  [WIDTH-1:0] data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_e;

  state_e           state_q;
  logic [15:0]      row_q, column_q;
  logic             we_q, re_q, oe_q;
  logic [WIDTH-1:0] wdata_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [WIDTH-1:0] rsp_rdata_q;

  logic [15:0]      row_d, column_d;
  logic             in_range;

  assign row_d    = 16'(1) << req_addr[7:4];
  assign column_d = 16'(1) << req_addr[3:0];
  assign in_range = ({1'b0, req_addr} < 9'(DEPTH));

  assign req_ready = (state_q == IDLE) || (state_q == RECOVER);
  assign row       = row_q;
  assign column    = column_q;
  assign we        = we_q;
  assign re        = re_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // Output enable is a flop and only ever set for writes, so no contention with re.
  assign data = oe_q ? wdata_q : {WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      column_q    <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      oe_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE, RECOVER: begin
          row_q    <= '0;
          column_q <= '0;
          we_q     <= 1'b0;
          re_q     <= 1'b0;
          oe_q     <= 1'b0;
          if (req_valid) begin
            wdata_q <= req_wdata;
            if (in_range) begin
              state_q  <= SETUP;
              row_q    <= row_d;
              column_q <= column_d;
              we_q     <= req_we;
              re_q     <= ~req_we;
              oe_q     <= req_we;
            end else begin
              // Rejected address: complete straight away without touching the bus.
              state_q     <= RECOVER;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
        end
        ACCESS: begin
          state_q     <= RECOVER;
          row_q       <= '0;
          column_q    <= '0;
          we_q        <= 1'b0;
          re_q        <= 1'b0;
          oe_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          if (re_q) begin
            rsp_rdata_q <= data;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssram_master.sv
// Directed bench for ssram_master with a behavioural responder on the shared bus
// (two-cycle select qualification, bit-set behaviour on row 2).
`timescale 1ns/1ps
module tb_ssram_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] row;
  logic [15:0] column;
  logic        we;
  logic        re;
  wire  [15:0] data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int act_cnt  = 0;

  ssram_master #(.WIDTH(16), .DEPTH(200)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .row       (row),
    .column    (column),
    .we        (we),
    .re        (re),
    .data      (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder model: acts only when select was also present the previous cycle.
  logic [15:0] mem [256];
  logic        sel_prev;
  int          r_idx, c_idx;
  logic [7:0]  baddr;
  logic        active;

  always_comb begin
    r_idx = 0;
    c_idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (row[i])    r_idx = i;
      if (column[i]) c_idx = i;
    end
  end
  assign baddr  = 8'(r_idx * 16 + c_idx);
  assign active = (row != 16'h0) && (column != 16'h0) && sel_prev;
  assign data   = (active && re) ? mem[baddr] : 16'hzzzz;

  initial begin
    sel_prev = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
  end

  always @(posedge clk) begin
    sel_prev <= (row != 16'h0) && (column != 16'h0);
    if (active && we) begin
      if (baddr[7:4] == 4'h2) mem[baddr] <= mem[baddr] | data;
      else                    mem[baddr] <= data;
      act_cnt <= act_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [15:0] wd,
                        input logic exp_err, input logic [15:0] exp_rd, input string tag);
    int n, lat, we_c, re_c, sel_c, both_c, a0;
    logic [15:0] seen_row, seen_col;
    lat = 0; we_c = 0; re_c = 0; sel_c = 0; both_c = 0;
    seen_row = 16'h0; seen_col = 16'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    a0 = act_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
      if (we) we_c++;
      if (re) re_c++;
      if (we && re) both_c++;
      if (row != 16'h0) begin
        sel_c++;
        seen_row = row;
        seen_col = column;
      end
    end
    check({tag, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'd3);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    check({tag, "_we_cycles"}, 32'(we_c), (w && !exp_err) ? 32'd2 : 32'd0);
    check({tag, "_re_cycles"}, 32'(re_c), (!w && !exp_err) ? 32'd2 : 32'd0);
    check({tag, "_we_and_re"}, 32'(both_c), 32'd0);
    check({tag, "_sel_cycles"}, 32'(sel_c), exp_err ? 32'd0 : 32'd2);
    check({tag, "_row_at_rsp"}, 32'(row), 32'd0);
    check({tag, "_row"}, 32'(seen_row), exp_err ? 32'd0 : 32'(16'h1 << a[7:4]));
    check({tag, "_col"}, 32'(seen_col), exp_err ? 32'd0 : 32'(16'h1 << a[3:0]));
    check({tag, "_actions"}, 32'(act_cnt - a0), (w && !exp_err) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_hold"}, 32'(rsp_rdata), 32'(exp_rd));
    $display("%s: %s addr=%02h wdata=%04h -> err=%0d rdata=%04h lat=%0d",
             tag, w ? "WR" : "RD", a, wd, rsp_err, rsp_rdata, lat);
  endtask

  task automatic b2b(input logic [7:0] a [4], input logic [15:0] d [4], input int n,
                     input string tag);
    int hs_prev, hs_now, zeros, k, a0;
    hs_prev = 0;
    a0 = act_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    for (int i = 0; i < n; i++) begin
      req_addr  = a[i];
      req_wdata = d[i];
      zeros = 0;
      k = 0;
      while (!req_ready && k < 10) begin
        if (row == 16'h0) zeros++;
        @(negedge clk);
        k++;
      end
      if (row == 16'h0) zeros++;
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 hs_now = cyc;
      if (i > 0) begin
        check({tag, "_spacing"}, 32'(hs_now - hs_prev), 32'd3);
        check({tag, "_gap"}, 32'(zeros), 32'd1);
      end
      $display("%s: WR addr=%02h wdata=%04h handshake at cycle %0d", tag, a[i], d[i], hs_now);
      hs_prev = hs_now;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_actions"}, 32'(act_cnt - a0), 32'(n));
  endtask

  initial begin
    logic [7:0]  ba [4];
    logic [15:0] bd [4];
    int a0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h0; req_wdata = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_row", 32'(row), 32'd0);
    check("rst_col", 32'(column), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_re", 32'(re), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b1;

    // Reset asserted during ACCESS of a write: strobes drop at once, no write lands.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05; req_wdata = 16'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    a0 = act_cnt;
    @(negedge clk);
    @(negedge clk);
    check("abort_we_in_access", 32'(we), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_we", 32'(we), 32'd0);
    check("abort_row", 32'(row), 32'd0);
    check("abort_col", 32'(column), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("abort_no_write", 32'(act_cnt - a0), 32'd0);
    $display("abort: WR addr=05 wdata=1234 cut by reset in ACCESS");
    access(1'b0, 8'h05, 16'h0,    1'b0, 16'h0000, "rd_05_after_abort");

    access(1'b0, 8'h10, 16'h0,    1'b0, 16'h0000, "rd_10");
    access(1'b1, 8'h3C, 16'hA5A5, 1'b0, 16'h0000, "wr_3c");
    access(1'b0, 8'h3C, 16'h0,    1'b0, 16'hA5A5, "rd_3c");
    access(1'b1, 8'h3D, 16'h0F0F, 1'b0, 16'hA5A5, "wr_3d_keeps_rdata");

    ba = '{8'h00, 8'h01, 8'h02, 8'h03};
    bd = '{16'h1110, 16'h2221, 16'h3332, 16'h4443};
    b2b(ba, bd, 4, "b2b");
    access(1'b0, 8'h00, 16'h0, 1'b0, 16'h1110, "rd_00");
    access(1'b0, 8'h01, 16'h0, 1'b0, 16'h2221, "rd_01");
    access(1'b0, 8'h02, 16'h0, 1'b0, 16'h3332, "rd_02");
    access(1'b0, 8'h03, 16'h0, 1'b0, 16'h4443, "rd_03");

    ba = '{8'h21, 8'h21, 8'h00, 8'h00};
    bd = '{16'h0001, 16'h0002, 16'h0000, 16'h0000};
    b2b(ba, bd, 2, "bitset");
    access(1'b0, 8'h21, 16'h0, 1'b0, 16'h0003, "rd_21");

    access(1'b0, 8'h3D, 16'h0,    1'b0, 16'h0F0F, "rd_3d");
    access(1'b0, 8'hC8, 16'h0,    1'b1, 16'h0000, "rd_c8_err");
    access(1'b0, 8'hC7, 16'h0,    1'b0, 16'h0000, "rd_c7_last");
    access(1'b1, 8'hFF, 16'hBEEF, 1'b1, 16'h0000, "wr_ff_err");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssram_master.md
# ssram_master

Bus initiator for the one-hot row/column register bus that serves the `ssram_register`/`ssram_bsrr`/`ssram_256` responders. It converts a single-request valid/ready interface into the row/column/we/re strobe sequence, drives `data` on writes, and captures it on reads. Responders act only when select is held two consecutive cycles, so the master guarantees a two-cycle strobe window and a select-free gap between accesses. One instance sits between the CPU-side interface logic and all register banks.

## Interface
- WIDTH, 16, data bus width
- DEPTH, 256, populated locations (1..256); addresses >= DEPTH are rejected
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  8  location; row = addr[7:4], column = addr[3:0]
- req_wdata  in  WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_err  out  1  qualifies rsp_valid: address out of range
- rsp_rdata  out  WIDTH  read data, held until next rsp_valid
- row  out  16  one-hot row select
- column  out  16  one-hot column select
- we  out  1  write strobe
- re  out  1  read strobe
- data  inout  WIDTH  shared bus; driven only during write SETUP/ACCESS

## Operation
- States: IDLE, SETUP, ACCESS, RECOVER.
- req_ready = (state == IDLE) | (state == RECOVER). Handshake = req_valid & req_ready; request fields are sampled into registers on the handshake edge; fields are don't-care otherwise.
- Handshake with req_addr < DEPTH -> SETUP. Handshake with req_addr >= DEPTH -> RECOVER, no strobes; rsp_valid=1, rsp_err=1, rsp_rdata=0 in that RECOVER cycle.
- SETUP: row = 1<<addr[7:4], column = 1<<addr[3:0]; we = req_we, re = ~req_we; on write, data driven with the latched wdata. -> ACCESS.
- ACCESS: all outputs identical to SETUP (responder's delayed select is now true). Write: responder latches on the edge ending ACCESS. Read: data sampled into rsp_rdata on the edge ending ACCESS. -> RECOVER.
- RECOVER: row = column = 0, we = re = 0, data released to Z. rsp_valid = 1, rsp_err = 0 for an in-range access. Handshake in this cycle -> SETUP (or back to RECOVER for out-of-range); else -> IDLE.
- IDLE: all strobes 0, data Z.
- row, column, we, re and data output-enable come straight from flops (no decode glitches on the bus).
- rsp_rdata updates only on read completions; write and error completions leave it unchanged except error forcing 0.
- Never assert we and re together; never drive data while re = 1.

## Timing
- Reset (rst low, async): state IDLE, req_ready=1, row=column=0, we=re=0, data Z, rsp_valid=0, rsp_err=0, rsp_rdata=0. Reset mid-access aborts immediately; a write aborted before its ACCESS edge is not performed.
- Handshake at edge 0 -> SETUP in cycle 1, ACCESS cycle 2, RECOVER cycle 3 with rsp_valid. Latency request-to-response 3 cycles.
- Back-to-back: next handshake in RECOVER -> next SETUP in cycle 4; sustained throughput one access per 3 cycles; at least one select-free cycle between any two accesses, including repeated access to the same address (protects bit-set/reset registers from double action).
- Error completion: handshake at edge 0 -> rsp_valid in cycle 1.

## Test plan
- Reset with rst low mid-ACCESS of write 0x1234 to addr 0x05 -> strobes drop asynchronously, data Z; subsequent read of 0x05 returns the pre-reset value (0 after register reset).
- Write 0xA5A5 to addr 0x3C, then read 0x3C -> SETUP shows row=0x0008, column=0x1000, we=1 for exactly 2 cycles; rsp_valid 3 cycles after each handshake; rsp_rdata=0xA5A5.
- req_valid held high for 4 writes to addrs 0x00..0x03 -> handshakes every 3 cycles, row/column zero for one cycle between each, all four values read back.
- Two consecutive writes to the same bit-set register address -> one select-free gap between them; each write causes exactly one set action.
- DEPTH=200, read addr 0xC8 -> no strobes, rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Read of addr 0x10 while monitoring bus -> master never drives data, we=0 throughout, re=1 exactly 2 cycles.
